// File: rtl/crc16_pkg.sv
// ----------------------------------------------------------------------------
// crc16_pkg
// Shared definitions for the CRC-16 receive checker (and transmit generator):
//   CRC16_POLY / CRC16_INIT : default polynomial and seed (MSB-first, no xorout)
//   state_t                 : checker FSM states
//   status_t                : per-frame verdict {ok, crc_err, len_err}
//   crc16_byte()            : 8 serial LFSR steps folded into one function
// ----------------------------------------------------------------------------
package crc16_pkg;

  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  typedef struct packed {
    logic ok;
    logic crc_err;
    logic len_err;
  } status_t;

  // MSB-first, non-reflected: data bit 7 enters the register first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc,
                                             input logic [7:0]  data,
                                             input logic [15:0] poly);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ poly;
    end
    return c;
  endfunction

endpackage

// File: rtl/crc16_byte_update.sv
// ----------------------------------------------------------------------------
// crc16_byte_update
// Combinational byte-parallel CRC-16 step: crc_o = f(crc_i, data_i).
// Ports:
//   crc_i  [15:0] current CRC register
//   data_i [7:0]  byte to absorb, bit 7 first
//   crc_o  [15:0] CRC register after the byte
// ----------------------------------------------------------------------------
module crc16_byte_update
  import crc16_pkg::*;
#(
  parameter logic [15:0] POLY = CRC16_POLY
) (
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  assign crc_o = crc16_byte(crc_i, data_i, POLY);

endmodule

// File: rtl/crc16_frame_checker.sv
// ----------------------------------------------------------------------------
// crc16_frame_checker
// Receive-side CRC-16 frame checker. Each frame is payload followed by the two
// CRC bytes (MSB byte first); running the CRC over the whole frame leaves a
// zero residue when the frame is intact.
//
// Handshake: a byte transfers on a rising clk edge where in_valid && in_ready.
// in_sof / in_eof are meaningful only on a transfer. in_ready drops only for
// the single REPORT cycle that follows an eof byte.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   in_data[7:0]      frame byte
//   in_valid          byte present
//   in_sof / in_eof   first / last byte of frame
//   in_ready          checker can accept a byte
//   frame_done        1-cycle pulse, status outputs just updated
//   crc_ok/crc_err/len_err  verdict of last completed frame (one-hot)
//   frame_abort       1-cycle pulse, open frame discarded by a new sof
//   payload_len       last frame byte count minus 2 (0 if count < 2)
//   residue[15:0]     CRC register at eof
//   state_dbg[1:0]    current FSM state
// ----------------------------------------------------------------------------
module crc16_frame_checker
  import crc16_pkg::*;
#(
  parameter logic [15:0] POLY    = CRC16_POLY,
  parameter logic [15:0] INIT    = CRC16_INIT,
  parameter int          CNT_W   = 12,
  parameter int          MIN_LEN = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic             in_eof,
  output logic             in_ready,
  output logic             frame_done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic             len_err,
  output logic             frame_abort,
  output logic [CNT_W-1:0] payload_len,
  output logic [15:0]      residue,
  output logic [1:0]       state_dbg
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q;
  logic [15:0]      crc_q;
  logic [CNT_W-1:0] count_q;
  status_t          status_q;
  logic             frame_done_q;
  logic             frame_abort_q;
  logic [CNT_W-1:0] payload_len_q;
  logic [15:0]      residue_q;

  logic             xfer;
  logic             accept;
  logic [15:0]      crc_seed;
  logic [15:0]      crc_d;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] payload_len_d;
  logic             len_bad;
  status_t          status_d;

  assign in_ready = (state_q != ST_REPORT);
  assign xfer     = in_valid && in_ready;
  // In IDLE only a sof byte opens a frame; stray bytes are dropped.
  assign accept   = xfer && (in_sof || (state_q == ST_DATA));

  // A sof byte always restarts from the seed, whether or not a frame is open.
  assign crc_seed = in_sof ? INIT : crc_q;

  crc16_byte_update #(.POLY(POLY)) u_byte_update (
    .crc_i  (crc_seed),
    .data_i (in_data),
    .crc_o  (crc_d)
  );

  always_comb begin
    count_d = count_q;
    if (in_sof)                  count_d = CNT_W'(1);
    else if (count_q != CNT_MAX) count_d = count_q + CNT_W'(1);

    payload_len_d = (count_d < CNT_W'(2)) ? '0 : (count_d - CNT_W'(2));

    len_bad          = (count_d < CNT_W'(MIN_LEN));
    status_d.len_err = len_bad;
    status_d.ok      = !len_bad && (crc_d == 16'h0000);
    status_d.crc_err = !len_bad && (crc_d != 16'h0000);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      crc_q         <= INIT;
      count_q       <= '0;
      status_q      <= '0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      payload_len_q <= '0;
      residue_q     <= '0;
    end else begin
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DATA: begin
          if (accept) begin
            crc_q   <= crc_d;
            count_q <= count_d;
            if ((state_q == ST_DATA) && in_sof) frame_abort_q <= 1'b1;
            if (in_eof) begin
              // Verdict is taken from the post-byte values so it is ready
              // during the REPORT cycle.
              state_q       <= ST_REPORT;
              frame_done_q  <= 1'b1;
              status_q      <= status_d;
              payload_len_q <= payload_len_d;
              residue_q     <= crc_d;
            end else begin
              state_q <= ST_DATA;
            end
          end
        end
        ST_REPORT: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign frame_done  = frame_done_q;
  assign frame_abort = frame_abort_q;
  assign crc_ok      = status_q.ok;
  assign crc_err     = status_q.crc_err;
  assign len_err     = status_q.len_err;
  assign payload_len = payload_len_q;
  assign residue     = residue_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_crc16_frame_checker.sv
// ----------------------------------------------------------------------------
// tb_crc16_frame_checker
// Table of whole frames with hand-computed verdicts, plus hand-written
// sequences for abort, back-to-back traffic and reset mid-frame.
// ----------------------------------------------------------------------------
module tb_crc16_frame_checker;
  import crc16_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid, in_sof, in_eof;
  logic        in_ready, frame_done, crc_ok, crc_err, len_err, frame_abort;
  logic [11:0] payload_len;
  logic [15:0] residue;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  crc16_frame_checker dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_sof      (in_sof),
    .in_eof      (in_eof),
    .in_ready    (in_ready),
    .frame_done  (frame_done),
    .crc_ok      (crc_ok),
    .crc_err     (crc_err),
    .len_err     (len_err),
    .frame_abort (frame_abort),
    .payload_len (payload_len),
    .residue     (residue),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Pulse monitor, sampled on the falling edge.
  int done_cnt = 0, ok_cnt = 0, abort_cnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) done_cnt++;
      if (frame_done && crc_ok) ok_cnt++;
      if (frame_abort) abort_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eof   = 1'b0;
    in_data  = 8'h00;
  endtask

  // Holds the byte until it is accepted; returns at #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] d, input logic sof, input logic eof,
                           output int stalls);
    logic rdy;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    in_eof   = eof;
    stalls   = 0;
    rdy = in_ready;
    @(posedge clk); #1;
    while (!rdy && stalls < 8) begin
      stalls++;
      rdy = in_ready;
      @(posedge clk); #1;
    end
    if (!rdy) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  // Bytes are left-justified in data; in_valid is left high at the end.
  task automatic send_frame(input logic [95:0] data, input int n, output int stalls);
    int s;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      send_byte(data[95-8*i -: 8], (i == 0), (i == n - 1), s);
      stalls += s;
    end
  endtask

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [95:0] data;
    int          n;
    logic        ok;
    logic        cerr;
    logic        lerr;
    logic [11:0] plen;
    logic        res_zero;
  } vec_t;

  localparam logic [95:0] GOOD = 96'h313233343536373839FEE800;

  vec_t vecs[6];
  int   st;
  int   d0, o0, a0;

  initial begin
    vecs[0] = '{"good",    GOOD,                         11, 1'b1, 1'b0, 1'b0, 12'd9, 1'b1};
    vecs[1] = '{"corrupt", 96'h313233343436373839FEE800, 11, 1'b0, 1'b1, 1'b0, 12'd9, 1'b0};
    vecs[2] = '{"len2",    96'h0,                          2, 1'b0, 1'b0, 1'b1, 12'd0, 1'b1};
    vecs[3] = '{"len3",    96'h0,                          3, 1'b1, 1'b0, 1'b0, 12'd1, 1'b1};
    vecs[4] = '{"len1_00", 96'h0,                          1, 1'b0, 1'b0, 1'b1, 12'd0, 1'b1};
    vecs[5] = '{"len1_a5", 96'hA50000000000000000000000,  1, 1'b0, 1'b0, 1'b1, 12'd0, 1'b0};

    // Reset state
    idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",      in_ready,    1);
    chk("rst_done",       frame_done,  0);
    chk("rst_ok",         crc_ok,      0);
    chk("rst_len_err",    len_err,     0);
    chk("rst_residue",    residue,     0);
    rst = 1'b0;
    cycle();
    chk("post_rst_ready", in_ready,    1);
    chk("post_rst_state", state_dbg,   ST_IDLE);

    // Table-driven frames
    foreach (vecs[v]) begin
      send_frame(vecs[v].data, vecs[v].n, st);
      idle();
      // eof accepted on the previous edge: this is the REPORT cycle
      chk({vecs[v].name, "_done"},    frame_done,          1);
      chk({vecs[v].name, "_ready0"},  in_ready,            0);
      chk({vecs[v].name, "_state"},   state_dbg,           ST_REPORT);
      chk({vecs[v].name, "_ok"},      crc_ok,              vecs[v].ok);
      chk({vecs[v].name, "_crc_err"}, crc_err,             vecs[v].cerr);
      chk({vecs[v].name, "_len_err"}, len_err,             vecs[v].lerr);
      chk({vecs[v].name, "_plen"},    payload_len,         vecs[v].plen);
      chk({vecs[v].name, "_res0"},    (residue == 16'h0),  vecs[v].res_zero);
      cycle();
      chk({vecs[v].name, "_done1"},   frame_done,          0);
      chk({vecs[v].name, "_ready1"},  in_ready,            1);
      chk({vecs[v].name, "_hold"},    crc_ok,              vecs[v].ok);
      chk({vecs[v].name, "_stalls"},  st,                  0);
    end

    // Abort: open frame of 4 bytes, then a new sof restarts a good frame
    d0 = done_cnt; a0 = abort_cnt; o0 = ok_cnt;
    send_byte(8'h31, 1'b1, 1'b0, st);
    send_byte(8'h32, 1'b0, 1'b0, st);
    send_byte(8'h33, 1'b0, 1'b0, st);
    send_byte(8'h34, 1'b0, 1'b0, st);
    send_byte(8'h31, 1'b1, 1'b0, st);
    chk("abort_pulse",    frame_abort, 1);
    chk("abort_no_done",  frame_done,  0);
    for (int i = 1; i < 11; i++) begin
      send_byte(GOOD[95-8*i -: 8], 1'b0, (i == 10), st);
      chk("abort_single", frame_abort, 0);
    end
    idle();
    chk("abort_done",     frame_done,  1);
    chk("abort_ok",       crc_ok,      1);
    chk("abort_plen",     payload_len, 9);
    cycle();
    chk("abort_cnt",      abort_cnt - a0, 1);
    chk("abort_done_cnt", done_cnt - d0,  1);
    chk("abort_ok_cnt",   ok_cnt - o0,    1);

    // Back-to-back with in_valid held high across two frames
    d0 = done_cnt; o0 = ok_cnt;
    begin
      int s1, s2;
      send_frame(GOOD, 11, s1);
      send_frame(GOOD, 11, s2);
      idle();
      chk("b2b_stall_a",  s1, 0);
      chk("b2b_stall_b",  s2, 1);
    end
    chk("b2b_done",     frame_done, 1);
    chk("b2b_ok",       crc_ok,     1);
    chk("b2b_plen",     payload_len, 9);
    cycle();
    chk("b2b_done_cnt", done_cnt - d0, 2);
    chk("b2b_ok_cnt",   ok_cnt - o0,   2);

    // Reset mid-frame
    for (int i = 0; i < 5; i++) send_byte(GOOD[95-8*i -: 8], (i == 0), 1'b0, st);
    idle();
    d0 = done_cnt; a0 = abort_cnt;
    #2 rst = 1'b1;
    #1;
    chk("mrst_ok",      crc_ok,      0);
    chk("mrst_plen",    payload_len, 0);
    chk("mrst_residue", residue,     0);
    chk("mrst_ready",   in_ready,    1);
    chk("mrst_state",   state_dbg,   ST_IDLE);
    @(posedge clk); #1;
    rst = 1'b0;
    cycle();
    chk("mrst_ready2",  in_ready,    1);
    // Bytes without sof are dropped, even one flagged eof
    send_byte(8'h36, 1'b0, 1'b0, st);
    send_byte(8'h37, 1'b0, 1'b1, st);
    idle();
    chk("drop_no_done", frame_done,  0);
    chk("drop_state",   state_dbg,   ST_IDLE);
    cycle();
    chk("drop_done_cnt",  done_cnt - d0,  0);
    chk("drop_abort_cnt", abort_cnt - a0, 0);
    send_frame(GOOD, 11, st);
    idle();
    chk("mrst_good_done", frame_done,  1);
    chk("mrst_good_ok",   crc_ok,      1);
    chk("mrst_good_plen", payload_len, 9);
    chk("mrst_good_res",  residue,     0);
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/crc16_frame_checker.md
Name: crc16_frame_checker

Overview:
Receive-side companion to the CRC-16 parallel generator. Consumes a byte stream framed by sof/eof flags, where each frame is the payload followed by the 2 transmitted CRC bytes (MSB byte first). Runs the same byte-parallel CRC-16 over the whole frame and reports pass/fail from the zero residue, plus length status. Sits between the byte deserializer and the packet buffer that commits or drops frames.

Parameters:
POLY, 16'h8005, generator polynomial, MSB-first, non-reflected
INIT, 16'h0000, CRC register value at start of frame; no final XOR
CNT_W, 12, width of the frame byte counter; saturates at 2^CNT_W-1
MIN_LEN, 3, minimum legal frame length in bytes, CRC bytes included

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_data  in  8  frame byte, bit 7 processed first
in_valid  in  1  byte present
in_sof  in  1  first byte of frame; qualified by in_valid
in_eof  in  1  last byte of frame (second CRC byte); qualified by in_valid
in_ready  out  1  checker can accept a byte
frame_done  out  1  one-cycle pulse: status outputs updated
crc_ok  out  1  last frame: residue zero and length legal
crc_err  out  1  last frame: length legal, residue nonzero
len_err  out  1  last frame: fewer than MIN_LEN bytes
frame_abort  out  1  one-cycle pulse: open frame discarded by a new sof
payload_len  out  CNT_W  last frame byte count minus 2; 0 if count < 2
residue  out  16  CRC register value at eof (debug)

Behaviour:
- Clock is clk. Reset rst is asynchronous and active-high.
- Reset: state=IDLE, crc_reg=INIT, count=0, all outputs 0 except in_ready=1.
- Transfer occurs when in_valid && in_ready. Bytes without in_valid are ignored. in_sof and in_eof are sampled only on a transfer.
- in_ready=1 in IDLE and DATA, and 0 in REPORT. No other backpressure.
- CRC update: crc_next = f(crc_reg, in_data). f is 8 serial steps of the MSB-first LFSR with POLY, computed in one cycle.
- FSM states:
  - IDLE: transfer with sof -> crc_reg=f(INIT,byte), count=1; go to REPORT if eof is also set, else DATA. Transfer without sof -> byte dropped, stay IDLE.
  - DATA: transfer without sof -> crc_reg=f(crc_reg,byte), count=count+1 (saturating); go to REPORT if eof.
  - DATA: transfer with sof -> frame_abort pulses the next cycle and the old frame is discarded with no frame_done. Restart as in IDLE: crc_reg=f(INIT,byte), count=1. eof on the same byte goes to REPORT.
  - REPORT: lasts exactly 1 cycle, then IDLE. The registered status is presented during it.
- Latency: eof byte transferred at cycle N -> frame_done=1 at cycle N+1, in_ready=0 at N+1, in_ready=1 again at N+2.
- Status at frame_done:
  - len_err=(count<MIN_LEN).
  - crc_ok=!len_err && residue==0.
  - crc_err=!len_err && residue!=0.
  - Exactly one of the three is 1.
- Status outputs and payload_len/residue hold until the next frame_done. They are cleared only by reset.
- Counter saturation does not affect CRC computation. payload_len saturates accordingly.
- Reset mid-frame discards all state immediately. No frame_done or frame_abort is generated.

Decomposition:
- crc16_pkg:
  - POLY/INIT defaults
  - state enum {IDLE, DATA, REPORT}
  - status struct {ok, crc_err, len_err}
  - function crc16_byte(crc, byte, poly)
- Sub-module crc16_byte_update: combinational 16-bit x 8-bit LFSR step, parameterised by POLY. It can be shared with the transmit generator.
- Top holds the FSM, counter, crc_reg and status registers.

Test Plan:
- Good frame: sof, "123456789" (0x31..0x39), then 0xFE, 0xE8 with eof -> at next cycle frame_done=1, crc_ok=1, residue=0x0000, payload_len=9.
- Corrupted frame: same as above with byte 0x35 changed to 0x34 -> crc_err=1, crc_ok=0, residue!=0, payload_len=9.
- Short frames:
  - 2-byte frame 0x00,0x00 (sof, then eof) -> len_err=1, payload_len=0.
  - 3-byte frame 0x00,0x00,0x00 -> crc_ok=1, payload_len=1.
  - sof+eof on one byte -> len_err=1.
- Abort: sof, 4 bytes, then a new sof mid-frame -> frame_abort pulses once, no frame_done. The new good frame "123456789"+FE E8 still reports crc_ok=1, payload_len=9.
- Back-to-back with backpressure: in_valid held high across two good frames -> in_ready=0 for exactly the REPORT cycle, no byte lost, two frame_done pulses with crc_ok=1.
- Reset mid-frame: assert rst after 5 bytes of a frame -> outputs return to 0 asynchronously and in_ready=1 after release. Bytes without sof are dropped; a subsequent good frame passes.
